seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
Serial pattern transmitter that produces the bit streams consumed by the team's serial sequence detectors. It accepts a parallel word through a valid/ready load port and shifts the word out MSB-first, one bit per clock. The word can be repeated a programmable number of times, with programmable idle gaps between repetitions. A one-cycle done pulse marks completion. The block sits upstream of a detector, either as a test stimulus source or as the transmit end of a serial link.

Parameters:
WORD_W, 4, width of the pattern word; bits per repetition.
CNT_W, 8, width of the repeat-count field.
GAP_W, 4, width of the inter-repetition gap field.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
load_valid  input  1  request to load a new job.
load_ready  output  1  high when a job can be accepted (state IDLE).
load_word  input  WORD_W  pattern to transmit, MSB sent first.
load_repeat  input  CNT_W  number of transmissions; 0 is treated as 1.
load_gap  input  GAP_W  idle cycles between repetitions; 0 means back-to-back.
seq_out  output  1  serial bit.
seq_valid  output  1  seq_out carries a pattern bit.
busy  output  1  a job is in progress (states SHIFT, GAP, DONE).
done  output  1  one-cycle pulse after the final bit of the final repetition.

Behaviour:
- Reset: rst is asynchronous and active-low. While rst=0, all state is cleared to IDLE.
- Reset values: seq_out=0, seq_valid=0, busy=0, done=0, load_ready=1. Internal counters and shift register are 0.
- Load inputs are ignored while rst=0.
- State machine states: IDLE, SHIFT, GAP, DONE. All outputs are decoded from registered state only; there are no combinational input-to-output paths.
- IDLE:
  - load_ready=1.
  - On an edge with load_valid=1, capture word, rep_left (load_repeat==0 ? 1 : load_repeat), gap and bit_idx=WORD_W-1, then go to SHIFT.
  - With load_valid=0, stay in IDLE.
- SHIFT:
  - seq_valid=1 and seq_out=word[bit_idx].
  - Each cycle bit_idx decrements.
  - When bit_idx==0, decrement rep_left. Then:
    - if rep_left was 1, go to DONE;
    - else if gap==0, stay in SHIFT with bit_idx=WORD_W-1 (no bubble);
    - else go to GAP with gap_cnt=gap.
- GAP:
  - seq_valid=0, seq_out=0 (see optional feature).
  - gap_cnt decrements each cycle. When gap_cnt==1, go to SHIFT with bit_idx=WORD_W-1.
  - Exactly `gap` idle cycles are produced.
- DONE: done=1 for exactly one cycle, load_ready=0, then go to IDLE.
- Latency: a job accepted at edge k drives its first bit during the cycle after edge k. Total job length is rep*WORD_W + (rep-1)*gap cycles in SHIFT/GAP, plus 1 cycle in DONE.
- Captured job fields are held stable for the whole job. load_valid outside IDLE is ignored, and load_* changes during a job have no effect.
- Counter widths: rep_left is CNT_W bits, gap_cnt is GAP_W bits, bit_idx is clog2(WORD_W) bits (minimum 1). No wrap-around occurs, because every counter stops at its terminal value.
- Reset mid-job: outputs return immediately to their reset values and the job is discarded. done is not pulsed.

Optional Feature:
Macro: SEQ_GEN_PRBS_EN.
- Defined:
  - A PRBS7 LFSR (polynomial x^7+x^6+1, reset seed 7'h7F) advances every cycle the state is not SHIFT, and holds during SHIFT.
  - In IDLE, GAP and DONE, seq_out=lfsr[6] with seq_valid=0. This provides filler noise to stress detectors.
- Not defined: seq_out=0 whenever seq_valid=0, and no LFSR logic is present.

Test Plan:
1. WORD_W=4; load 4'b1011, repeat=1, gap=0, accepted at edge k -> seq_out 1,0,1,1 with seq_valid=1 in cycles k+1..k+4; done=1 in cycle k+5 only; load_ready=1 from cycle k+6; busy=1 in cycles k+1..k+5.
2. Load 4'b1011, repeat=3, gap=0 -> 12 contiguous valid bits 101110111011, no seq_valid bubble, then a single done pulse.
3. Load 4'b1011, repeat=2, gap=2 -> valid 1011, two cycles seq_valid=0 (seq_out=0 without the macro), valid 1011, then done. With SEQ_GEN_PRBS_EN, gap-cycle seq_out matches the PRBS7 reference model.
4. Load 4'b0110 with repeat=0 -> exactly one transmission (0,1,1,0), then done.
5. Assert load_valid with load_word=4'b1111 during SHIFT -> load_ready=0, the stream continues with the original word, and the second request is accepted only after returning to IDLE.
6. Pull rst low after 2 bits of a repeat=5 job -> seq_valid, busy and done go to 0 immediately with no done pulse. After rst goes high, load_ready=1 and a fresh 4'b1011 job transmits correctly.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter feeding the sequence detectors.
// A job (word, repeat count, gap length) is accepted through a valid/ready
// load port in IDLE. The word is shifted out MSB-first, one bit per clock,
// and repeated the requested number of times. Optionally there are idle gap
// cycles between repetitions. A one-cycle done pulse closes the job.
//
// Build option: define SEQ_GEN_PRBS_EN to drive PRBS7 filler noise on
// seq_out whenever seq_valid is low. Without it, seq_out is 0 in those cycles.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a job, load_ready=1
// S_SHIFT | driving word[bit_idx] with seq_valid=1
// S_GAP   | idle cycles between repetitions, seq_valid=0
// S_DONE  | one-cycle done pulse, then back to S_IDLE

module seq_pattern_gen #(
    parameter int WORD_W = 4,
    parameter int CNT_W  = 8,
    parameter int GAP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WORD_W-1:0] load_word,
    input  logic [CNT_W-1:0]  load_repeat,
    input  logic [GAP_W-1:0]  load_gap,
    output logic              seq_out,
    output logic              seq_valid,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] IDX_TOP = BIT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_nxt;
    logic [CNT_W-1:0]  rep_left;
    logic [CNT_W-1:0]  rep_left_nxt;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_nxt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_cnt_nxt;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  bit_idx_nxt;
    logic              filler;

    // State and job registers; async active-low clear discards any job in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            word_q   <= '0;
            rep_left <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            bit_idx  <= '0;
        end else begin
            state    <= state_nxt;
            word_q   <= word_nxt;
            rep_left <= rep_left_nxt;
            gap_q    <= gap_nxt;
            gap_cnt  <= gap_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
        end
    end

    // Next-state and counter update; every down-counter stops at its terminal value.
    always_comb begin
        state_nxt    = state;
        word_nxt     = word_q;
        rep_left_nxt = rep_left;
        gap_nxt      = gap_q;
        gap_cnt_nxt  = gap_cnt;
        bit_idx_nxt  = bit_idx;
        case (state)
            S_IDLE: begin
                if (load_valid) begin
                    word_nxt     = load_word;
                    rep_left_nxt = (load_repeat == '0) ? REP_ONE : load_repeat;
                    gap_nxt      = load_gap;
                    bit_idx_nxt  = IDX_TOP;
                    state_nxt    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_idx == '0) begin
                    rep_left_nxt = rep_left - REP_ONE;
                    if (rep_left == REP_ONE) begin
                        state_nxt = S_DONE;
                    end else if (gap_q == '0) begin
                        // back-to-back repetition, no bubble on seq_valid
                        bit_idx_nxt = IDX_TOP;
                    end else begin
                        gap_cnt_nxt = gap_q;
                        state_nxt   = S_GAP;
                    end
                end else begin
                    bit_idx_nxt = bit_idx - BIT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_ONE) begin
                    gap_cnt_nxt = '0;
                    bit_idx_nxt = IDX_TOP;
                    state_nxt   = S_SHIFT;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_ONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef SEQ_GEN_PRBS_EN
    logic [6:0] lfsr;

    // PRBS7 (x^7 + x^6 + 1) filler generator; frozen while real bits are shifting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 7'h7F;
        end else if (state != S_SHIFT) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    assign filler = lfsr[6];
`else
    assign filler = 1'b0;
`endif

    // Outputs are decoded from registered state only.
    assign load_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign seq_valid  = (state == S_SHIFT);
    assign seq_out    = seq_valid ? word_q[bit_idx] : filler;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: scoreboard bench for seq_pattern_gen.
// The stimulus pushes the expected cycle-by-cycle job stream when a job is
// accepted. The monitor compares every negedge against the head of the queue,
// or against the idle pattern when the queue is empty.
module tb_seq_pattern_gen;

    localparam int WORD_W = 4;
    localparam int CNT_W  = 8;
    localparam int GAP_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [WORD_W-1:0] load_word = '0;
    logic [CNT_W-1:0]  load_repeat = '0;
    logic [GAP_W-1:0]  load_gap = '0;
    logic              seq_out;
    logic              seq_valid;
    logic              busy;
    logic              done;

    seq_pattern_gen #(.WORD_W(WORD_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_word   (load_word),
        .load_repeat (load_repeat),
        .load_gap    (load_gap),
        .seq_out     (seq_out),
        .seq_valid   (seq_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        bit sbit;
        bit dn;
    } item_t;

    item_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Filler reference: PRBS7 from seed 7F, stepping on every non-shift cycle.
    logic [6:0] lfsr_m = 7'h7F;
    bit         cur_shift = 1'b0;

    function automatic logic fill_bit();
`ifdef SEQ_GEN_PRBS_EN
        return lfsr_m[6];
`else
        return 1'b0;
`endif
    endfunction

    // Expected stream of one job: each repetition's bits, gaps between, then done.
    task automatic push_model(input logic [WORD_W-1:0] w, input logic [CNT_W-1:0] r,
                              input logic [GAP_W-1:0] g);
        int    reps;
        item_t it;
        reps = (r == '0) ? 1 : int'(r);
        for (int k = 0; k < reps; k++) begin
            for (int i = WORD_W - 1; i >= 0; i--) begin
                it.valid = 1'b1; it.sbit = w[i]; it.dn = 1'b0;
                exp_q.push_back(it);
            end
            if (k < reps - 1) begin
                for (int j = 0; j < int'(g); j++) begin
                    it.valid = 1'b0; it.sbit = 1'b0; it.dn = 1'b0;
                    exp_q.push_back(it);
                end
            end
        end
        it.valid = 1'b0; it.sbit = 1'b0; it.dn = 1'b1;
        exp_q.push_back(it);
    endtask

    // Monitor: one comparison of {busy, load_ready, seq_valid, seq_out, done} per cycle.
    logic [4:0] mon_act;
    logic [4:0] mon_exp;
    item_t      mon_it;
    always @(negedge clk) begin
        mon_act = {busy, load_ready, seq_valid, seq_out, done};
        if (!rst) begin
            exp_q.delete();
            lfsr_m    = 7'h7F;
            cur_shift = 1'b0;
            mon_exp   = {1'b0, 1'b1, 1'b0, fill_bit(), 1'b0};
        end else if (exp_q.size() > 0) begin
            mon_it    = exp_q.pop_front();
            cur_shift = mon_it.valid;
            mon_exp   = {1'b1, 1'b0, mon_it.valid,
                         mon_it.valid ? mon_it.sbit : fill_bit(), mon_it.dn};
        end else begin
            cur_shift = 1'b0;
            mon_exp   = {1'b0, 1'b1, 1'b0, fill_bit(), 1'b0};
        end
        n_vec++;
        if (mon_act !== mon_exp) begin
            n_err++;
            $display("FAIL cycle t=%0t {busy,ready,valid,out,done} actual=%b required=%b",
                     $time, mon_act, mon_exp);
        end
    end

    // Advance the filler reference at the same edges the DUT would.
    always @(posedge clk) begin
        if (!rst) lfsr_m = 7'h7F;
        else if (!cur_shift) lfsr_m = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
    end

    task automatic scramble();
        load_word   = WORD_W'($urandom);
        load_repeat = CNT_W'($urandom);
        load_gap    = GAP_W'($urandom);
    endtask

    // Wait for IDLE (fields scrambled meanwhile), present a job, and record its stream.
    task automatic issue(input logic [WORD_W-1:0] w, input logic [CNT_W-1:0] r,
                         input logic [GAP_W-1:0] g);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (load_ready) break;
            scramble();
            n++;
            if (n > 5000) begin
                n_vec++;
                n_err++;
                $display("FAIL ready_timeout actual load_ready=0 required 1");
                return;
            end
        end
        load_word   = w;
        load_repeat = r;
        load_gap    = g;
        load_valid  = 1'b1;
        @(posedge clk);
        #1;
        push_model(w, r, g);
        load_valid = 1'b0;
        scramble();
    endtask

    initial begin
        logic [3:0] imm;
        int         n;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        issue(4'b1011, 8'd1, 4'd0);
        issue(4'b1011, 8'd3, 4'd0);
        issue(4'b1011, 8'd2, 4'd2);
        issue(4'b0110, 8'd0, 4'd0);

        // request during SHIFT must be ignored
        issue(4'b1011, 8'd3, 4'd0);
        for (int i = 0; i < 4; i++) begin
            load_valid  = 1'b1;
            load_word   = 4'b1111;
            load_repeat = 8'd1;
            load_gap    = 4'd0;
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        issue(4'b1111, 8'd1, 4'd0);

        // reset in the middle of a long job
        issue(4'b1011, 8'd5, 4'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        imm = {busy, seq_valid, done, load_ready};
        n_vec++;
        if (imm !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_now {busy,valid,done,ready} actual=%b required=0001", imm);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        issue(4'b1011, 8'd1, 4'd0);

        // counter boundaries
        issue(4'b1001, 8'd255, 4'd0);
        issue(4'b1001, 8'd2, 4'd15);
        issue(4'b0001, 8'd2, 4'd1);

        for (int j = 0; j < 40; j++) begin
            issue(WORD_W'($urandom), CNT_W'($urandom_range(0, 4)),
                  GAP_W'($urandom_range(0, 3)));
        end

        n = 0;
        while ((exp_q.size() > 0) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout actual pending=%0d required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
